gate_sweep_checker: RTL and testbench
=====================================

// Module: gate_sweep_checker
// PURPOSE
//  Stimulus source and result checker that sits directly upstream of the basic gate library.
//  It drives the shared operands a/b into the seven 2-input/1-input gate instances
//  (AND, OR, NOT, NAND, NOR, XOR, XNOR) and sweeps all four input combinations.
//  It samples the seven gate outputs and compares them against a built-in golden model.
//  It counts mismatches and reports pass/fail through a start/busy/done handshake.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles a/b are held stable before gate outputs are sampled (legal range 1..15)
//  ERR_W          6  width of the mismatch counter (saturating; 28 possible mismatches)
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request a sweep; sampled only in IDLE
//  busy       out  1      high from the cycle after start is accepted until DONE
//  done       out  1      one-cycle pulse at the end of a sweep
//  pass       out  1      1 = last sweep had zero mismatches; held until next start
//  a          out  1      operand A to every gate (registered)
//  b          out  1      operand B to every gate (registered; ignored by NOT)
//  gate_y     in   7      gate outputs: [0]AND [1]OR [2]NOT(a) [3]NAND [4]NOR [5]XOR [6]XNOR
//  err_cnt    out  ERR_W  number of mismatching (vector, gate) pairs in the last sweep
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, pass, a, b and err_cnt are all 0; vec=0; settle count=0.
//  - FSM states and transitions:
//    - IDLE: on start go to DRIVE, with vec=0 and err_cnt cleared to 0.
//    - DRIVE: a=vec[1], b=vec[0]; hold SETTLE_CYCLES cycles, then go to CHECK.
//    - CHECK: compare gate_y against golden(a,b); add popcount(mismatch) to err_cnt, saturating.
//      If vec==3, go to DONE; otherwise vec++ and go to DRIVE.
//    - DONE: done=1 and pass=(err_cnt==0) for one cycle; then go to IDLE.
//  - Vector order is 00, 01, 10, 11 (ab). a and b hold their last value when not in DRIVE/CHECK.
//  - Latency: with start high at edge 0, DRIVE begins in cycle 1.
//    done asserts in cycle 1 + 4*(SETTLE_CYCLES+1); this is cycle 9 for the default parameter.
//  - busy=1 in DRIVE and CHECK, and 0 in IDLE and DONE.
//  - start is ignored while busy or in DONE; no queuing.
//  - gate_y is used only in CHECK; values in any other state are don't-care.
//  - Reset mid-sweep aborts immediately to the reset values above; no done pulse is produced.
//  - Golden model per bit:
//    - AND a&b, OR a|b, NOT ~a
//    - NAND ~(a&b), NOR ~(a|b)
//    - XOR a^b, XNOR ~(a^b)
// CONFIGURATION
//  GATE_CHK_FAIL_LOG_EN defined:
//    - Adds output fail_vec[1:0] and output fail_mask[6:0].
//    - Both capture the vector and mismatch bits of the FIRST failing CHECK in a sweep.
//    - Both are cleared to 0 on reset and on an accepted start.
//    - Both hold their value after DONE.
//  GATE_CHK_FAIL_LOG_EN undefined:
//    - These ports and registers do not exist.
//    - All other behaviour is identical.
// STRUCTURE
//  - Package gate_chk_pkg holds:
//    - Gate bit-index localparams (GATE_AND=0 .. GATE_XNOR=6) and NUM_GATES=7.
//    - The FSM state encoding (IDLE, DRIVE, CHECK, DONE).
//    - Function golden_y(a,b), returning the expected 7-bit vector.
//  - One sub-module, gate_golden: combinational a,b -> expected[6:0], built from the package function.
//  - FSM, settle counter, vector counter, popcount/saturating accumulator and fail log stay in this module.
// TESTING
//  1. All seven library gates wired correctly, start pulse at cycle 0.
//     -> done in cycle 9, pass=1, err_cnt=0, a/b sequence 00,01,10,11.
//  2. gate_y[5] (XOR) forced to 0.
//     -> err_cnt=2, pass=0.
//     -> With GATE_CHK_FAIL_LOG_EN: fail_vec=01, fail_mask=7'b0100000.
//  3. gate_y[2] (NOT) forced to 1.
//     -> err_cnt=2 (vectors 10, 11), pass=0.
//  4. gate_y forced to ~golden on every vector.
//     -> err_cnt=28; with ERR_W=4, err_cnt saturates at 15.
//  5. start re-pulsed at cycles 3 and 9, then rst at cycle 5 of a second sweep.
//     -> Extra starts are ignored.
//     -> rst returns all outputs to 0 next edge, and no done pulse occurs.
//  6. SETTLE_CYCLES=3, correct gates.
//     -> done in cycle 17; each a/b value is held for 4 cycles; pass=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg
// Shared definitions for the gate sweep checker:
//   - bit positions of each gate inside the 7-bit gate output vector
//   - FSM state encoding used by gate_sweep_checker
//   - golden_y(a, b): reference output vector of the basic gate library
package gate_chk_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;
  localparam int NUM_GATES = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // NOT only looks at operand a; b is ignored for that bit.
  function automatic logic [NUM_GATES-1:0] golden_y(input logic a, input logic b);
    logic [NUM_GATES-1:0] y;
    y            = '0;
    y[GATE_AND]  = a & b;
    y[GATE_OR]   = a | b;
    y[GATE_NOT]  = ~a;
    y[GATE_NAND] = ~(a & b);
    y[GATE_NOR]  = ~(a | b);
    y[GATE_XOR]  = a ^ b;
    y[GATE_XNOR] = ~(a ^ b);
    return y;
  endfunction

endpackage

// File: rtl/gate_golden.sv
// gate_golden
// Combinational golden model of the basic gate library.
// Ports:
//   a, b      in  operands currently driven to the library
//   expected  out expected gate outputs, bit order as in gate_chk_pkg
module gate_golden
  import gate_chk_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  assign expected = golden_y(a, b);

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// Drives operands a/b into the seven library gates, sweeping ab = 00,01,10,11,
// samples the gate outputs after SETTLE_CYCLES and counts (vector, gate)
// mismatches against the golden model. Reports through start/busy/done.
// Parameters:
//   SETTLE_CYCLES  cycles a/b are held before sampling (1..15)
//   ERR_W          width of the saturating mismatch counter (>= 3)
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      sweep request, only honoured in IDLE
//   busy       high while driving/checking
//   done       one-cycle pulse at the end of a sweep
//   pass       last sweep had zero mismatches, held until next start
//   a, b       registered operands to the gate library
//   gate_y     gate outputs [0]AND [1]OR [2]NOT [3]NAND [4]NOR [5]XOR [6]XNOR
//   err_cnt    mismatch count of the last sweep
// Optional feature (macro GATE_CHK_FAIL_LOG_EN):
//   fail_vec, fail_mask  vector and mismatch bits of the first failing check
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 6
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 a,
  output logic                 b,
  input  logic [NUM_GATES-1:0] gate_y,
  output logic [ERR_W-1:0]     err_cnt
`ifdef GATE_CHK_FAIL_LOG_EN
  ,
  output logic [1:0]           fail_vec,
  output logic [NUM_GATES-1:0] fail_mask
`endif
);

  localparam int       SUM_W       = ERR_W + 1;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [1:0]           vec;
  logic [1:0]           vec_inc;
  logic [3:0]           settle_cnt;
  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] mismatch;
  logic [3:0]           mismatch_cnt;
  logic [SUM_W-1:0]     err_sum;
  logic [ERR_W-1:0]     err_next;

  gate_golden u_golden (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // Popcount of the mismatch bits and saturating accumulation. The sum is one
  // bit wider than the counter, so its MSB flags an overflow and clamps to max.
  always_comb begin
    mismatch     = gate_y ^ expected;
    mismatch_cnt = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      mismatch_cnt = mismatch_cnt + 4'(mismatch[i]);
    end
    err_sum  = {1'b0, err_cnt} + SUM_W'(mismatch_cnt);
    err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    vec_inc  = vec + 2'd1;
  end

  // Sweep FSM. a/b are loaded on every transition into DRIVE so they are
  // already valid in the first DRIVE cycle and stay stable through CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      a          <= 1'b0;
      b          <= 1'b0;
      err_cnt    <= '0;
      vec        <= '0;
      settle_cnt <= '0;
`ifdef GATE_CHK_FAIL_LOG_EN
      fail_vec   <= '0;
      fail_mask  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= DRIVE;
            busy       <= 1'b1;
            pass       <= 1'b0;
            vec        <= 2'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            settle_cnt <= '0;
            err_cnt    <= '0;
`ifdef GATE_CHK_FAIL_LOG_EN
            fail_vec   <= '0;
            fail_mask  <= '0;
`endif
          end
        end

        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        CHECK: begin
          err_cnt <= err_next;
`ifdef GATE_CHK_FAIL_LOG_EN
          // An all-zero mask means nothing has failed yet in this sweep.
          if ((fail_mask == '0) && (mismatch != '0)) begin
            fail_vec  <= vec;
            fail_mask <= mismatch;
          end
`endif
          if (vec == 2'd3) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            vec   <= vec_inc;
            a     <= vec_inc[1];
            b     <= vec_inc[0];
            state <= DRIVE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker
// Self-checking bench for gate_sweep_checker. Two instances run side by side:
// dut0 with default parameters and dut1 with SETTLE_CYCLES=3, ERR_W=4.
// Each instance drives a behavioural gate library whose outputs can be
// corrupted per vector (invert mask) or forced to 0/1 per bit.
// With GATE_CHK_FAIL_LOG_EN defined the fail log ports are checked as well.
module tb_gate_sweep_checker;

  localparam int S0  = 1;
  localparam int S1  = 3;
  localparam int EW0 = 6;
  localparam int EW1 = 4;
  localparam int L0  = 1 + 4 * (S0 + 1);
  localparam int L1  = 1 + 4 * (S1 + 1);

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic           busy0, done0, pass0, a0, b0;
  logic [6:0]     gy0;
  logic [EW0-1:0] err0;
  logic           busy1, done1, pass1, a1, b1;
  logic [6:0]     gy1;
  logic [EW1-1:0] err1;
`ifdef GATE_CHK_FAIL_LOG_EN
  logic [1:0] fv0, fv1;
  logic [6:0] fm0, fm1;
`endif

  logic [6:0] inv_v [4];
  logic [6:0] force0;
  logic [6:0] force1;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string      name;
    logic [6:0] force0;
    logic [6:0] force1;
    logic [6:0] inv;
    int         raw;
    logic [1:0] fvec;
    logic [6:0] fmask;
  } vec_rec_t;

  vec_rec_t vectors [7];

  always #5 clk = ~clk;

  // Truth table of the library, bit order [6]XNOR .. [0]AND.
  function automatic logic [6:0] truth(input logic av, input logic bv);
    return {~(av ^ bv), av ^ bv, ~(av | bv), ~(av & bv), ~av, av | bv, av & bv};
  endfunction

  // Behavioural gate library with fault injection, one copy per instance.
  always_comb begin
    gy0 = ((truth(a0, b0) ^ inv_v[{a0, b0}]) & ~force0) | force1;
    gy1 = ((truth(a1, b1) ^ inv_v[{a1, b1}]) & ~force1_mask_unused()) | force1;
  end

  function automatic logic [6:0] force1_mask_unused();
    return force0;
  endfunction

  gate_sweep_checker #(.SETTLE_CYCLES(S0), .ERR_W(EW0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0), .pass(pass0),
    .a(a0), .b(b0), .gate_y(gy0), .err_cnt(err0)
`ifdef GATE_CHK_FAIL_LOG_EN
    , .fail_vec(fv0), .fail_mask(fm0)
`endif
  );

  gate_sweep_checker #(.SETTLE_CYCLES(S1), .ERR_W(EW1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1), .pass(pass1),
    .a(a1), .b(b1), .gate_y(gy1), .err_cnt(err1)
`ifdef GATE_CHK_FAIL_LOG_EN
    , .fail_vec(fv1), .fail_mask(fm1)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] f0, input logic [6:0] f1,
                               input logic [6:0] i0, input logic [6:0] i1,
                               input logic [6:0] i2, input logic [6:0] i3);
    force0   = f0;
    force1   = f1;
    inv_v[0] = i0;
    inv_v[1] = i1;
    inv_v[2] = i2;
    inv_v[3] = i3;
  endtask

  // Reference: total mismatches over the four vectors and the first failing one.
  task automatic modelSweep(output int raw, output logic [1:0] fvec, output logic [6:0] fmask);
    logic [1:0] vv;
    logic [6:0] seen;
    logic [6:0] diff;
    raw   = 0;
    fvec  = '0;
    fmask = '0;
    for (int v = 0; v < 4; v++) begin
      vv   = 2'(v);
      seen = ((truth(vv[1], vv[0]) ^ inv_v[v]) & ~force0) | force1;
      diff = seen ^ truth(vv[1], vv[0]);
      raw  = raw + $countones(diff);
      if ((fmask == '0) && (diff != '0)) begin
        fvec  = vv;
        fmask = diff;
      end
    end
  endtask

  // One full sweep on both instances, checking timing, a/b order, busy and results.
  task automatic runSweep(input string tag, input int raw, input logic [1:0] efv, input logic [6:0] efm);
    int d0_at = 0, d1_at = 0, d0_n = 0, d1_n = 0;
    bit ab0_ok = 1, ab1_ok = 1, bz0_ok = 1, bz1_ok = 1;
    int ev;
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= L1 + 3; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (done0) begin d0_n++; if (d0_at == 0) d0_at = t; end
      if (done1) begin d1_n++; if (d1_at == 0) d1_at = t; end
      if (t < L0) begin
        ev = (t - 1) / (S0 + 1);
        if ({a0, b0} != 2'(ev)) ab0_ok = 0;
        if (!busy0) bz0_ok = 0;
      end else if (busy0) bz0_ok = 0;
      if (t < L1) begin
        ev = (t - 1) / (S1 + 1);
        if ({a1, b1} != 2'(ev)) ab1_ok = 0;
        if (!busy1) bz1_ok = 0;
      end else if (busy1) bz1_ok = 0;
    end
    checkOutput({tag, "_done_cycle0"}, d0_at, L0);
    checkOutput({tag, "_done_cycle1"}, d1_at, L1);
    checkOutput({tag, "_done_pulses"}, d0_n + d1_n, 2);
    checkOutput({tag, "_ab_seq"}, {ab0_ok, ab1_ok}, 2'b11);
    checkOutput({tag, "_busy"}, {bz0_ok, bz1_ok}, 2'b11);
    checkOutput({tag, "_ab_hold"}, {a0, b0, a1, b1}, 4'hF);
    checkOutput({tag, "_err0"}, err0, (raw > 63) ? 63 : raw);
    checkOutput({tag, "_err1"}, err1, (raw > 15) ? 15 : raw);
    checkOutput({tag, "_pass"}, {pass0, pass1}, (raw == 0) ? 2'b11 : 2'b00);
`ifdef GATE_CHK_FAIL_LOG_EN
    checkOutput({tag, "_fail_vec"}, {fv0, fv1}, {efv, efv});
    checkOutput({tag, "_fail_mask"}, {fm0, fm1}, {efm, efm});
`endif
  endtask

  initial begin
    int         raw;
    logic [1:0] fvec;
    logic [6:0] fmask;
    int         d_n;
    bit         bz_ok;

    vectors[0] = '{"correct",   7'h00, 7'h00, 7'h00, 0,  2'b00, 7'b0000000};
    vectors[1] = '{"xor_low",   7'h20, 7'h00, 7'h00, 2,  2'b01, 7'b0100000};
    vectors[2] = '{"not_high",  7'h00, 7'h04, 7'h00, 2,  2'b10, 7'b0000100};
    vectors[3] = '{"invert",    7'h00, 7'h00, 7'h7F, 28, 2'b00, 7'b1111111};
    vectors[4] = '{"all_low",   7'h7F, 7'h00, 7'h00, 14, 2'b00, 7'b1011100};
    vectors[5] = '{"all_high",  7'h00, 7'h7F, 7'h00, 14, 2'b00, 7'b0100011};
    vectors[6] = '{"and_high",  7'h00, 7'h01, 7'h00, 3,  2'b00, 7'b0000001};

    rst   = 1'b1;
    start = 1'b0;
    applyStimulus(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {busy0, done0, pass0, busy1, done1, pass1}, 6'b0);
    checkOutput("reset_ab", {a0, b0, a1, b1}, 4'b0);
    checkOutput("reset_err", {err0, err1}, '0);
`ifdef GATE_CHK_FAIL_LOG_EN
    checkOutput("reset_fail_log", {fv0, fm0, fv1, fm1}, '0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vectors[i].force0, vectors[i].force1, vectors[i].inv,
                    vectors[i].inv, vectors[i].inv, vectors[i].inv);
      runSweep(vectors[i].name, vectors[i].raw, vectors[i].fvec, vectors[i].fmask);
    end

    // Extra starts at cycles 3 and 9 must be ignored.
    applyStimulus(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    @(negedge clk);
    start = 1'b1;
    d_n   = 0;
    bz_ok = 1;
    for (int t = 1; t <= L1 + 3; t++) begin
      @(negedge clk);
      if (done0) begin
        d_n++;
        checkOutput("restart_done_cycle", t, L0);
      end
      if (t > L0 && busy0) bz_ok = 0;
      if (done1) checkOutput("restart_done1_cycle", t, L1);
      start = (t == 3) || (t == 9);
    end
    checkOutput("restart_done_count", d_n, 1);
    checkOutput("restart_no_resweep", bz_ok, 1);
    checkOutput("restart_pass", {pass0, pass1}, 2'b11);

    // Reset in the middle of a sweep aborts with no done pulse.
    applyStimulus(7'h00, 7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("mid_err0", err0, 14);
    checkOutput("mid_err1", err1, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_ctrl", {busy0, done0, pass0, busy1, done1, pass1}, 6'b0);
    checkOutput("abort_ab", {a0, b0, a1, b1}, 4'b0);
    checkOutput("abort_err", {err0, err1}, '0);
`ifdef GATE_CHK_FAIL_LOG_EN
    checkOutput("abort_fail_log", {fv0, fm0, fv1, fm1}, '0);
`endif
    d_n   = 0;
    bz_ok = 1;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (done0 || done1) d_n++;
      if (busy0 || busy1) bz_ok = 0;
    end
    checkOutput("abort_no_done", d_n, 0);
    checkOutput("abort_idle", bz_ok, 1);

    // Random per-vector corruption against the reference model.
    for (int r = 0; r < 20; r++) begin
      applyStimulus(7'h00, 7'h00,
                    ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom),
                    ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom),
                    ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom),
                    ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom));
      modelSweep(raw, fvec, fmask);
      runSweep($sformatf("rand%0d", r), raw, fvec, fmask);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
